sram_uart_tx_interface: RTL and testbench

Reads a range of 16-bit words from the external SRAM and streams them out of the UART TX pin, high byte first, then low byte. It is the upload path, the inverse of the UART-to-SRAM download path, and lets the host read back decompressed image data. It contains its own 8N1 UART serializer. It drives SRAM_we_n high at all times, so it never writes SRAM.

---
 rtl/sram_uart_tx_interface.sv | 163 ++++++++++++++++
 tb/tb_sram_uart_tx_interface.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_uart_tx_interface.sv
// SRAM-to-UART upload path: reads words Start..End from SRAM and sends
// each one as two 8N1 frames, high byte first.
module sram_uart_tx_interface #(
    parameter int CLKS_PER_BIT      = 434,
    parameter int SRAM_READ_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Initialize,
    input  logic        Enable,
    input  logic [17:0] Start_address,
    input  logic [17:0] End_address,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int WW = $clog2(SRAM_READ_LATENCY + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SRAM_READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READ,
        S_LATCH,
        S_SEND_HIGH,
        S_SEND_LOW
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [BW-1:0]   baud_cnt;
    logic [3:0]      bit_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [17:0]     end_q;
    logic [15:0]     word;
    logic [7:0]      shift;
    logic            fin;
    logic            tx_d;
    logic            fin_d;

    logic sending;
    logic bit_end;
    logic frame_end;
    logic wait_end;
    logic last;
    logic empty;
    logic accept;

    assign sending   = (state == S_SEND_HIGH) || (state == S_SEND_LOW);
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign frame_end = sending && bit_end && (bit_cnt == 4'd9);
    assign wait_end  = (wait_cnt == WAIT_LAST);
    assign last      = (SRAM_address == end_q);
    assign empty     = (End_address < Start_address);
    assign accept    = (state == S_IDLE) && Enable && !Busy;
    assign SRAM_we_n = 1'b1;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            state <= S_IDLE;
        else if (Initialize)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:      if (accept && !empty) state_n = S_WAIT_READ;
            S_WAIT_READ: if (wait_end) state_n = S_LATCH;
            S_LATCH:     state_n = S_SEND_HIGH;
            S_SEND_HIGH: if (frame_end) state_n = S_SEND_LOW;
            S_SEND_LOW:  if (frame_end) state_n = last ? S_IDLE : S_WAIT_READ;
            default:     state_n = S_IDLE;
        endcase
    end

    // The line lags the counters by one register stage, so Done is
    // delayed one more cycle to coincide with the end of the stop bit.
    always_comb begin
        tx_d  = 1'b1;
        fin_d = (accept && empty) ||
                ((state == S_SEND_LOW) && frame_end && last);
        if (sending) begin
            if (bit_cnt == 4'd0)
                tx_d = 1'b0;
            else if (bit_cnt == 4'd9)
                tx_d = 1'b1;
            else
                tx_d = shift[0];
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address <= '0;
            UART_TX_O    <= 1'b1;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            fin          <= 1'b0;
            end_q        <= '0;
            word         <= '0;
            shift        <= '0;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
        end else if (Initialize) begin
            SRAM_address <= '0;
            UART_TX_O    <= 1'b1;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            fin          <= 1'b0;
            end_q        <= '0;
            word         <= '0;
            shift        <= '0;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
        end else begin
            UART_TX_O <= tx_d;
            fin       <= fin_d;
            Done      <= fin;
            if (fin)
                Busy <= 1'b0;
            else if (accept && !empty)
                Busy <= 1'b1;
            if (accept)
                end_q <= End_address;
            if (accept && !empty)
                SRAM_address <= Start_address;
            else if ((state == S_SEND_LOW) && frame_end && !last)
                SRAM_address <= SRAM_address + 18'd1;
            wait_cnt <= (state == S_WAIT_READ) ? wait_cnt + WW'(1) : '0;
            if (state == S_LATCH)
                word <= SRAM_read_data;
            if (sending) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    bit_cnt  <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
                end else begin
                    baud_cnt <= baud_cnt + BW'(1);
                end
            end else begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
            // Byte is loaded as the start bit ends, shifted after each data bit.
            if (sending && bit_end) begin
                if (bit_cnt == 4'd0)
                    shift <= (state == S_SEND_HIGH) ? word[15:8] : word[7:0];
                else if (bit_cnt != 4'd9)
                    shift <= shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Directed bench for sram_uart_tx_interface with a 2-cycle SRAM model
// and a bit-sampling UART receiver.
module tb_sram_uart_tx_interface;

    localparam int CPB = 4;
    localparam int LAT = 2;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Initialize = 1'b0;
    logic        Enable = 1'b0;
    logic [17:0] Start_address = '0;
    logic [17:0] End_address = '0;
    logic [15:0] SRAM_read_data = '0;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic        UART_TX_O;
    logic        Busy;
    logic        Done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        we_bad = 1'b0;
    logic [15:0] mem [16];
    logic [15:0] d1 = '0;

    sram_uart_tx_interface #(
        .CLKS_PER_BIT(CPB),
        .SRAM_READ_LATENCY(LAT)
    ) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .Initialize(Initialize),
        .Enable(Enable),
        .Start_address(Start_address),
        .End_address(End_address),
        .SRAM_read_data(SRAM_read_data),
        .SRAM_address(SRAM_address),
        .SRAM_we_n(SRAM_we_n),
        .UART_TX_O(UART_TX_O),
        .Busy(Busy),
        .Done(Done)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        cyc            <= cyc + 1;
        d1             <= mem[SRAM_address[3:0]];
        SRAM_read_data <= d1;
    end

    always @(negedge Clock)
        if (SRAM_we_n !== 1'b1) we_bad <= 1'b1;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output int sc);
        int n;
        n = 0;
        while (UART_TX_O !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        chk("start_bit_seen", 32'(n < 2000), 32'd1);
        sc = cyc;
    endtask

    task automatic rx_frame(output logic [9:0] f, output int sc);
        wait_start(sc);
        tick();
        f[0] = UART_TX_O;
        for (int j = 1; j < 10; j++) begin
            repeat (CPB) tick();
            f[j] = UART_TX_O;
        end
    endtask

    task automatic rx_word(input logic [15:0] w, input string tag,
                           output int sh, output int sl);
        logic [9:0] f;
        rx_frame(f, sh);
        chk({tag, "_hi"}, 32'(f), 32'({1'b1, w[15:8], 1'b0}));
        rx_frame(f, sl);
        chk({tag, "_lo"}, 32'(f), 32'({1'b1, w[7:0], 1'b0}));
        chk({tag, "_b2b"}, sl - sh, 40);
    endtask

    task automatic wait_done(output int dc);
        int n;
        n = 0;
        while (Done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(n < 3000), 32'd1);
        dc = cyc;
    endtask

    initial begin
        int ke, sh, sl, dc, bad, seen, s;
        int shs [4];
        int sls [4];
        logic [15:0] exp_w [4];
        logic [9:0] f;
        exp_w = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0]  = 16'h0102;
        mem[1]  = 16'h0304;
        mem[2]  = 16'h0506;
        mem[3]  = 16'h0708;
        mem[5]  = 16'hA53C;
        mem[15] = 16'h5AC3;

        repeat (3) tick();
        chk("rst_tx", 32'(UART_TX_O), 32'd1);
        chk("rst_addr", 32'(SRAM_address), 32'd0);
        chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        Resetn = 1'b1;
        bad = 0;
        repeat (1000) begin
            tick();
            if (UART_TX_O !== 1'b1 || SRAM_address !== 18'd0 ||
                Busy !== 1'b0 || Done !== 1'b0) bad++;
        end
        chk("idle_1000", bad, 0);

        Start_address = 18'd5;
        End_address   = 18'd5;
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        ke = cyc;
        chk("single_busy", 32'(Busy), 32'd1);
        chk("single_addr", 32'(SRAM_address), 32'd5);
        rx_word(16'hA53C, "single", sh, sl);
        chk("single_first_lat", sh - ke, LAT + 2);
        chk("single_busy_late", 32'(Busy), 32'd1);
        wait_done(dc);
        chk("single_done_80", dc - sh, 80);
        chk("single_busy_fall", 32'(Busy), 32'd0);
        tick();
        chk("single_done_once", 32'(Done), 32'd0);

        repeat (5) tick();
        Start_address = 18'd0;
        End_address   = 18'd3;
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_word(exp_w[i], $sformatf("multi%0d", i), shs[i], sls[i]);
            if (i > 0)
                chk($sformatf("multi_gap%0d", i), shs[i] - sls[i-1] - 40, LAT + 1);
        end
        wait_done(dc);
        chk("multi_end_addr", 32'(SRAM_address), 32'd3);
        chk("multi_we_n", 32'(we_bad), 32'd0);

        repeat (5) tick();
        Start_address = 18'd10;
        End_address   = 18'd9;
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        seen = 0;
        bad = 0;
        repeat (4) begin
            if (Done === 1'b1) seen++;
            if (Busy !== 1'b0 || UART_TX_O !== 1'b1) bad++;
            tick();
        end
        chk("empty_done_pulse", seen, 1);
        chk("empty_busy_tx", bad, 0);
        chk("empty_addr", 32'(SRAM_address), 32'd3);

        Start_address = 18'd5;
        End_address   = 18'd5;
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        wait_start(s);
        repeat (13) tick();
        chk("abort_pre_busy", 32'(Busy), 32'd1);
        Initialize = 1'b1;
        tick();
        Initialize = 1'b0;
        chk("abort_tx", 32'(UART_TX_O), 32'd1);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_addr", 32'(SRAM_address), 32'd0);
        bad = 0;
        repeat (100) begin
            tick();
            if (UART_TX_O !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) bad++;
        end
        chk("abort_quiet", bad, 0);
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        rx_word(16'hA53C, "restart", sh, sl);
        wait_done(dc);
        chk("restart_done_80", dc - sh, 80);

        repeat (5) tick();
        Enable = 1'b1;
        Initialize = 1'b1;
        tick();
        Enable = 1'b0;
        Initialize = 1'b0;
        bad = 0;
        repeat (50) begin
            if (UART_TX_O !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) bad++;
            tick();
        end
        chk("init_wins", bad, 0);

        Start_address = 18'h3FFFF;
        End_address   = 18'h3FFFF;
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        rx_frame(f, sh);
        chk("top_hi", 32'(f), 32'({1'b1, 8'h5A, 1'b0}));
        Start_address = 18'd0;
        End_address   = 18'd3;
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        chk("top_busy_ignore", 32'(Busy), 32'd1);
        rx_frame(f, sl);
        chk("top_lo", 32'(f), 32'({1'b1, 8'hC3, 1'b0}));
        chk("top_b2b", sl - sh, 40);
        wait_done(dc);
        chk("top_done_80", dc - sh, 80);
        chk("top_addr", 32'(SRAM_address), 32'h3FFFF);
        bad = 0;
        repeat (100) begin
            tick();
            if (UART_TX_O !== 1'b1 || Busy !== 1'b0 ||
                SRAM_address !== 18'h3FFFF) bad++;
        end
        chk("top_no_more", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
